// File: rtl/sum_serializer_if.sv
// rtl/sum_serializer_if.sv - sum input and word output handshake bundle
interface sum_serializer_if #(
    parameter int ADDER_WIDTH = 80,
    parameter int WORD_WIDTH  = 16
);
    logic [ADDER_WIDTH:0]    sum;
    logic                    sum_valid;
    logic                    sum_ready;
    logic [WORD_WIDTH-1:0]   word_data;
    logic                    word_valid;
    logic                    word_ready;
    logic                    word_last;

    modport master (
        input  sum, sum_valid, word_ready,
        output sum_ready, word_data, word_valid, word_last
    );

    modport slave (
        output sum, sum_valid, word_ready,
        input  sum_ready, word_data, word_valid, word_last
    );
endinterface

// File: rtl/sum_serializer.sv
// rtl/sum_serializer.sv - splits a wide adder result into LS-first word beats
module sum_serializer #(
    parameter int ADDER_WIDTH = 80,
    parameter int WORD_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sum_serializer_if.master       bus,
    output logic [15:0]            frames_sent,
    output logic [15:0]            drop_count
);
    localparam int SUM_W   = ADDER_WIDTH + 1;
    localparam int BEATS   = (SUM_W + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SHIFT_W = BEATS * WORD_WIDTH;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]         state;
    logic [SHIFT_W-1:0] shreg;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat_fire;
    logic               frame_done;
    logic               accept;

    assign bus.word_valid = (state == ST_SEND);
    assign bus.word_last  = bus.word_valid && (beat_cnt == CNT_W'(BEATS - 1));
    // Gate the data so IDLE shows zero regardless of leftover shift contents.
    assign bus.word_data  = bus.word_valid ? shreg[WORD_WIDTH-1:0] : '0;
    assign bus.sum_ready  = (state == ST_IDLE) || (bus.word_last && bus.word_ready);

    assign beat_fire  = bus.word_valid && bus.word_ready;
    assign frame_done = beat_fire && bus.word_last;
    assign accept     = bus.sum_valid && bus.sum_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            beat_cnt    <= '0;
            frames_sent <= '0;
            drop_count  <= '0;
        end else begin
            if (accept) begin
                shreg    <= SHIFT_W'(bus.sum);
                beat_cnt <= '0;
                state    <= ST_SEND;
            end else if (frame_done) begin
                state    <= ST_IDLE;
            end else if (beat_fire) begin
                shreg    <= shreg >> WORD_WIDTH;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (frame_done)
                frames_sent <= frames_sent + 16'd1;
            if (bus.sum_valid && !bus.sum_ready)
                drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_sum_serializer.sv
// tb/tb_sum_serializer.sv - directed scoreboard bench for sum_serializer
module tb_sum_serializer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] frames_sent, drop_count;
    logic [15:0] frames2, drops2;
    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    sum_serializer_if #(.ADDER_WIDTH(80), .WORD_WIDTH(16)) bus ();
    sum_serializer_if #(.ADDER_WIDTH(7),  .WORD_WIDTH(8))  bus2 ();

    sum_serializer #(.ADDER_WIDTH(80), .WORD_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .frames_sent(frames_sent), .drop_count(drop_count)
    );

    // Single-beat variant reaches the 16-bit counter wrap in ~64k cycles.
    sum_serializer #(.ADDER_WIDTH(7), .WORD_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .frames_sent(frames2), .drop_count(drops2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [80:0] v);
        logic [95:0] x;
        x = {15'd0, v};
        for (int i = 0; i < 6; i++)
            sb.push_back({(i == 5), x[i*16 +: 16]});
    endtask

    task automatic send_sum(input logic [80:0] v);
        push_frame(v);
        bus.sum       = v;
        bus.sum_valid = 1'b1;
        @(negedge clk);
        chk("sum_ready_on_send", bus.sum_ready, 1);
        @(posedge clk);
        #1 bus.sum_valid = 1'b0;
    endtask

    task automatic drain(input logic [15:0] exp_frames);
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1 chk("drain_empty", sb.size(), 0);
        @(negedge clk);
        chk("frames_after_drain", frames_sent, exp_frames);
        chk("idle_valid", bus.word_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.word_valid && bus.word_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", bus.word_data, 0);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("beat_data", bus.word_data, e[15:0]);
                chk("beat_last", bus.word_last, e[16]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.sum = '0;  bus.sum_valid = 1'b0;  bus.word_ready = 1'b0;
        bus2.sum = '0; bus2.sum_valid = 1'b0; bus2.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_word_valid", bus.word_valid, 0);
        chk("rst_word_last", bus.word_last, 0);
        chk("rst_word_data", bus.word_data, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_sum_ready", bus.sum_ready, 1);

        // Basic frame with the fixed beat list, 1-cycle latency, 1 beat/cycle
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        sb.push_back({1'b0, 16'h2345}); sb.push_back({1'b0, 16'hEF01});
        sb.push_back({1'b0, 16'hABCD}); sb.push_back({1'b0, 16'h6789});
        sb.push_back({1'b0, 16'h2345}); sb.push_back({1'b1, 16'h0001});
        bus.sum = 81'h1_2345_6789_ABCD_EF01_2345;
        bus.sum_valid = 1'b1;
        @(posedge clk);
        #1 bus.sum_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", bus.word_valid, 1);
        repeat (6) @(posedge clk);
        #1 chk("throughput_empty", sb.size(), 0);
        @(negedge clk);
        chk("basic_frames", frames_sent, 1);
        chk("basic_idle_last", bus.word_last, 0);
        chk("basic_idle_data", bus.word_data, 0);

        // Backpressure on beat 2
        @(posedge clk);
        #1 send_sum(81'h1_2345_6789_ABCD_EF01_2345);
        @(posedge clk);
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_data", bus.word_data, 16'hABCD);
            chk("bp_hold_valid", bus.word_valid, 1);
            chk("bp_hold_last", bus.word_last, 0);
        end
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        drain(16'd2);

        // Back-to-back frames, second offered on the last handshake
        @(posedge clk);
        #1 send_sum(81'h1_2345_6789_ABCD_EF01_2345);
        repeat (5) @(posedge clk);
        #1 push_frame(81'h0_0000_0000_0000_0000_FFFF);
        bus.sum = 81'h0_0000_0000_0000_0000_FFFF;
        bus.sum_valid = 1'b1;
        @(negedge clk);
        chk("b2b_sum_ready", bus.sum_ready, 1);
        chk("b2b_last", bus.word_last, 1);
        @(posedge clk);
        #1 bus.sum_valid = 1'b0;
        @(negedge clk);
        chk("b2b_no_gap_valid", bus.word_valid, 1);
        chk("b2b_first_beat", bus.word_data, 16'hFFFF);
        drain(16'd4);

        // Drops while stalled mid-frame
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        send_sum(81'h0_1111_2222_3333_4444_5555);
        bus.sum = 81'h1_DEAD_BEEF_0000_0000_0000;
        bus.sum_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.sum_valid = 1'b0;
        @(negedge clk);
        chk("drop_count", drop_count, 3);
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        drain(16'd5);

        // Reset at beat 3 aborts the frame
        @(posedge clk);
        #1 send_sum(81'h0_AAAA_BBBB_CCCC_DDDD_EEEE);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_valid", bus.word_valid, 0);
        chk("midrst_frames", frames_sent, 0);
        chk("midrst_data", bus.word_data, 0);
        @(posedge clk);
        #1 send_sum(81'h0_0102_0304_0506_0708_090A);
        drain(16'd1);

        // Counter wrap on the single-beat instance
        @(posedge clk);
        #1 bus2.word_ready = 1'b1;
        bus2.sum = 8'h5A;
        bus2.sum_valid = 1'b1;
        begin
            int n = 0;
            while (frames2 !== 16'hFFFF && n < 70000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("wrap_pre", frames2, 16'hFFFF);
        chk("wrap_data", bus2.word_data, 8'h5A);
        chk("wrap_last", bus2.word_last, 1);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_frames", frames2, 0);
        chk("wrap_no_drops", drops2, 0);
        #1 bus2.sum_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
